// File: rtl/pixel_readout_pkg.sv
// Shared types and defaults for the pixel readout capture path.
package pixel_readout_pkg;

    localparam int unsigned PIX_BITS_DEF    = 8;
    localparam int unsigned PIX_PER_ROW_DEF = 2;

    typedef enum logic {
        ST_IDLE,
        ST_STREAM
    } stream_state_t;

    // One captured frame: [row][pixel][bit], row 0 in the low half.
    typedef logic [1:0][PIX_PER_ROW_DEF-1:0][PIX_BITS_DEF-1:0] frame_t;

endpackage

// File: rtl/pixel_frame_dbuf.sv
// Two-entry frame store with write/read indices and full flags.
module pixel_frame_dbuf #(
    parameter int unsigned FRAME_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [FRAME_W-1:0] wr_frame,
    input  logic               rel,
    output logic [FRAME_W-1:0] rd_frame_c,
    output logic               rd_full_c,
    output logic               accept_c
);

    logic [1:0][FRAME_W-1:0] mem_q;
    logic [1:0]              full_q, full_n;
    logic                    wr_q, wr_n;
    logic                    rd_q, rd_n;

    assign rd_frame_c = mem_q[rd_q];
    assign rd_full_c  = full_q[rd_q];

    // Release is applied before the write so a same-cycle completion can reuse the slot.
    always_comb begin
        full_n   = full_q;
        wr_n     = wr_q;
        rd_n     = rd_q;
        accept_c = 1'b0;
        if (rel) begin
            full_n[rd_q] = 1'b0;
            rd_n         = ~rd_q;
        end
        if (wr_en && !full_n[wr_q]) begin
            accept_c     = 1'b1;
            full_n[wr_q] = 1'b1;
            wr_n         = ~wr_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q  <= '0;
            full_q <= '0;
            wr_q   <= 1'b0;
            rd_q   <= 1'b0;
        end else begin
            if (accept_c) begin
                mem_q[wr_q] <= wr_frame;
            end
            full_q <= full_n;
            wr_q   <= wr_n;
            rd_q   <= rd_n;
        end
    end

endmodule

// File: rtl/pixel_readout_capture.sv
// Captures 2x2 pixel frames from the array readout bus and streams them out.
module pixel_readout_capture
    import pixel_readout_pkg::*;
#(
    parameter int unsigned PIX_BITS    = PIX_BITS_DEF,
    parameter int unsigned PIX_PER_ROW = PIX_PER_ROW_DEF,
    parameter int unsigned CNT_BITS    = 8
) (
    input  logic                            CLK,
    input  logic                            RESET,
    input  logic                            READ1,
    input  logic                            READ2,
    input  logic [PIX_BITS*PIX_PER_ROW-1:0] DATA_OUT,
    input  logic                            CLR_FLAGS,
    output logic [PIX_BITS-1:0]             PIX_DATA,
    output logic                            PIX_VALID,
    input  logic                            PIX_READY,
    output logic                            PIX_SOF,
    output logic                            PIX_EOF,
    output logic [CNT_BITS-1:0]             FRAME_COUNT,
    output logic                            OVERFLOW,
    output logic                            ROW_ERR
);

    localparam int unsigned ROW_W         = PIX_BITS * PIX_PER_ROW;
    localparam int unsigned FRAME_W       = 2 * ROW_W;
    localparam int unsigned PIX_PER_FRAME = 2 * PIX_PER_ROW;
    localparam int unsigned IDX_W         = $clog2(PIX_PER_FRAME);

    logic             r1_q, r2_q;
    logic [ROW_W-1:0] row0_q, row1_q;
    logic             row0_ok_q;
    logic             r1_end, r2_end, both, complete;
    logic             rel_c, accept_c, rd_full_c;
    logic [FRAME_W-1:0] rd_frame_c;

    stream_state_t      state_q, state_n;
    logic [IDX_W-1:0]   idx_q, idx_n;
    logic [PIX_BITS-1:0] data_n;
    logic               valid_n, sof_n, eof_n;

    assign r1_end   = r1_q & ~READ1;
    assign r2_end   = r2_q & ~READ2;
    assign both     = READ1 & READ2;
    assign complete = r2_end & row0_ok_q;

    pixel_frame_dbuf #(
        .FRAME_W (FRAME_W)
    ) u_dbuf (
        .clk        (CLK),
        .rst        (RESET),
        .wr_en      (complete),
        .wr_frame   ({row1_q, row0_q}),
        .rel        (rel_c),
        .rd_frame_c (rd_frame_c),
        .rd_full_c  (rd_full_c),
        .accept_c   (accept_c)
    );

    // Phase tracking, row holding registers, sticky flags and frame counter.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r1_q        <= 1'b0;
            r2_q        <= 1'b0;
            row0_q      <= '0;
            row1_q      <= '0;
            row0_ok_q   <= 1'b0;
            FRAME_COUNT <= '0;
            OVERFLOW    <= 1'b0;
            ROW_ERR     <= 1'b0;
        end else begin
            r1_q <= READ1;
            r2_q <= READ2;
            if (READ1) row0_q <= DATA_OUT;
            if (READ2) row1_q <= DATA_OUT;

            if (both)          row0_ok_q <= 1'b0;
            else if (r1_end)   row0_ok_q <= 1'b1;
            else if (complete) row0_ok_q <= 1'b0;

            if (accept_c) FRAME_COUNT <= FRAME_COUNT + CNT_BITS'(1);

            if (complete && !accept_c)               OVERFLOW <= 1'b1;
            else if (CLR_FLAGS)                      OVERFLOW <= 1'b0;

            if (both || (r2_end && !row0_ok_q))      ROW_ERR <= 1'b1;
            else if (CLR_FLAGS)                      ROW_ERR <= 1'b0;
        end
    end

    // Stream FSM next state and registered output values.
    always_comb begin
        state_n = state_q;
        idx_n   = idx_q;
        data_n  = PIX_DATA;
        valid_n = PIX_VALID;
        sof_n   = PIX_SOF;
        eof_n   = PIX_EOF;
        rel_c   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rd_full_c) begin
                    state_n = ST_STREAM;
                    idx_n   = '0;
                    data_n  = rd_frame_c[PIX_BITS-1:0];
                    valid_n = 1'b1;
                    sof_n   = 1'b1;
                    eof_n   = 1'b0;
                end
            end
            ST_STREAM: begin
                if (PIX_VALID && PIX_READY) begin
                    if (idx_q == IDX_W'(PIX_PER_FRAME - 1)) begin
                        rel_c   = 1'b1;
                        state_n = ST_IDLE;
                        valid_n = 1'b0;
                        sof_n   = 1'b0;
                        eof_n   = 1'b0;
                    end else begin
                        idx_n  = idx_q + IDX_W'(1);
                        data_n = rd_frame_c[(int'(idx_q) + 1) * PIX_BITS +: PIX_BITS];
                        sof_n  = 1'b0;
                        eof_n  = (idx_q == IDX_W'(PIX_PER_FRAME - 2));
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            PIX_DATA  <= '0;
            PIX_VALID <= 1'b0;
            PIX_SOF   <= 1'b0;
            PIX_EOF   <= 1'b0;
        end else begin
            state_q   <= state_n;
            idx_q     <= idx_n;
            PIX_DATA  <= data_n;
            PIX_VALID <= valid_n;
            PIX_SOF   <= sof_n;
            PIX_EOF   <= eof_n;
        end
    end

endmodule

// File: tb/tb_pixel_readout_capture.sv
// Directed bench for pixel_readout_capture: vector table plus corner-case sequences.
module tb_pixel_readout_capture;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        READ1, READ2, CLR_FLAGS, PIX_READY;
    logic [15:0] DATA_OUT;
    logic [7:0]  PIX_DATA;
    logic        PIX_VALID, PIX_SOF, PIX_EOF;
    logic [7:0]  FRAME_COUNT;
    logic        OVERFLOW, ROW_ERR;

    int n_vec = 0;
    int n_bad = 0;

    logic [7:0] got_px[$];
    logic       got_sof[$];
    logic       got_eof[$];
    logic [7:0] exp_px[$];

    typedef struct packed {
        logic        r1, r2;
        logic [15:0] d;
        logic        rdy, clr;
        logic        v, sof, eof, ovf, err;
        logic [7:0]  cnt;
        logic [7:0]  px;
    } vec_t;

    localparam int NV = 29;
    vec_t tbl[NV];

    pixel_readout_capture dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .READ1       (READ1),
        .READ2       (READ2),
        .DATA_OUT    (DATA_OUT),
        .CLR_FLAGS   (CLR_FLAGS),
        .PIX_DATA    (PIX_DATA),
        .PIX_VALID   (PIX_VALID),
        .PIX_READY   (PIX_READY),
        .PIX_SOF     (PIX_SOF),
        .PIX_EOF     (PIX_EOF),
        .FRAME_COUNT (FRAME_COUNT),
        .OVERFLOW    (OVERFLOW),
        .ROW_ERR     (ROW_ERR)
    );

    always #5 CLK = ~CLK;

    function automatic vec_t mk(input logic r1, r2, input logic [15:0] d, input logic rdy, clr,
                                input logic v, sof, eof, ovf, err, input logic [7:0] cnt, px);
        vec_t t;
        t = {r1, r2, d, rdy, clr, v, sof, eof, ovf, err, cnt, px};
        return t;
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        RESET = 1'b1; READ1 = 1'b0; READ2 = 1'b0; DATA_OUT = '0;
        CLR_FLAGS = 1'b0; PIX_READY = 1'b0;
        step(); step();
        RESET = 1'b0;
    endtask

    task automatic do_frame(input logic [15:0] d0, d1, input logic rdy1, rdy2);
        READ1 = 1'b1; READ2 = 1'b0; DATA_OUT = d0; PIX_READY = rdy1;
        repeat (3) step();
        READ1 = 1'b0; READ2 = 1'b1; DATA_OUT = d1; PIX_READY = rdy2;
        repeat (3) step();
        READ2 = 1'b0; DATA_OUT = '0;
        step();
    endtask

    task automatic add_frame(input logic [15:0] d0, d1);
        exp_px.push_back(d0[7:0]);
        exp_px.push_back(d0[15:8]);
        exp_px.push_back(d1[7:0]);
        exp_px.push_back(d1[15:8]);
    endtask

    // Accepts every pixel offered over a bounded window, then compares with exp_px.
    task automatic collect_check(input string name, input int max_cyc);
        int n;
        got_px.delete(); got_sof.delete(); got_eof.delete();
        PIX_READY = 1'b1;
        for (int i = 0; i < max_cyc; i++) begin
            if (PIX_VALID) begin
                got_px.push_back(PIX_DATA);
                got_sof.push_back(PIX_SOF);
                got_eof.push_back(PIX_EOF);
            end
            step();
        end
        chk({name, "_npix"}, 32'(got_px.size()), 32'(exp_px.size()));
        n = (got_px.size() < exp_px.size()) ? got_px.size() : exp_px.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_px%0d", name, i),
                {22'd0, got_sof[i], got_eof[i], got_px[i]},
                {22'd0, (i % 4) == 0, (i % 4) == 3, exp_px[i]});
        end
        exp_px.delete();
    endtask

    initial begin
        tbl[0]  = mk(1, 0, 16'hA1B2, 1, 0, 0, 0, 0, 0, 0, 8'd0, 8'h00);
        tbl[1]  = tbl[0];
        tbl[2]  = tbl[0];
        tbl[3]  = mk(0, 1, 16'hC3D4, 1, 0, 0, 0, 0, 0, 0, 8'd0, 8'h00);
        tbl[4]  = tbl[3];
        tbl[5]  = tbl[3];
        tbl[6]  = mk(0, 0, 16'h0000, 1, 0, 0, 0, 0, 0, 0, 8'd1, 8'h00);
        tbl[7]  = mk(0, 0, 16'h0000, 1, 0, 1, 1, 0, 0, 0, 8'd1, 8'hB2);
        tbl[8]  = mk(0, 0, 16'h0000, 1, 0, 1, 0, 0, 0, 0, 8'd1, 8'hA1);
        tbl[9]  = mk(0, 0, 16'h0000, 1, 0, 1, 0, 0, 0, 0, 8'd1, 8'hD4);
        tbl[10] = mk(0, 0, 16'h0000, 1, 0, 1, 0, 1, 0, 0, 8'd1, 8'hC3);
        tbl[11] = mk(0, 0, 16'h0000, 1, 0, 0, 0, 0, 0, 0, 8'd1, 8'h00);
        tbl[12] = mk(1, 0, 16'h1122, 1, 0, 0, 0, 0, 0, 0, 8'd1, 8'h00);
        tbl[13] = tbl[12];
        tbl[14] = tbl[12];
        tbl[15] = mk(0, 1, 16'h3344, 1, 0, 0, 0, 0, 0, 0, 8'd1, 8'h00);
        tbl[16] = tbl[15];
        tbl[17] = tbl[15];
        tbl[18] = mk(0, 0, 16'h0000, 1, 0, 0, 0, 0, 0, 0, 8'd2, 8'h00);
        tbl[19] = mk(0, 0, 16'h0000, 1, 0, 1, 1, 0, 0, 0, 8'd2, 8'h22);
        tbl[20] = mk(0, 0, 16'h0000, 1, 0, 1, 0, 0, 0, 0, 8'd2, 8'h11);
        tbl[21] = mk(0, 0, 16'h0000, 1, 0, 1, 0, 0, 0, 0, 8'd2, 8'h44);
        for (int i = 22; i < 27; i++)
            tbl[i] = mk(0, 0, 16'h0000, 0, 0, 1, 0, 0, 0, 0, 8'd2, 8'h44);
        tbl[27] = mk(0, 0, 16'h0000, 1, 0, 1, 0, 1, 0, 0, 8'd2, 8'h33);
        tbl[28] = mk(0, 0, 16'h0000, 1, 0, 0, 0, 0, 0, 0, 8'd2, 8'h00);

        // Reset state
        RESET = 1'b1; READ1 = 1'b0; READ2 = 1'b0; DATA_OUT = '0;
        CLR_FLAGS = 1'b0; PIX_READY = 1'b0;
        step(); step();
        chk("reset_state", {11'd0, PIX_VALID, PIX_SOF, PIX_EOF, OVERFLOW, ROW_ERR, FRAME_COUNT, PIX_DATA}, 32'd0);
        RESET = 1'b0;

        // Nominal frame and backpressure at pixel index 2
        for (int i = 0; i < NV; i++) begin
            READ1 = tbl[i].r1; READ2 = tbl[i].r2; DATA_OUT = tbl[i].d;
            PIX_READY = tbl[i].rdy; CLR_FLAGS = tbl[i].clr;
            step();
            chk($sformatf("vec%0d", i),
                {11'd0, PIX_VALID, PIX_SOF, PIX_EOF, OVERFLOW, ROW_ERR, FRAME_COUNT,
                 PIX_VALID ? PIX_DATA : 8'h00},
                {11'd0, tbl[i].v, tbl[i].sof, tbl[i].eof, tbl[i].ovf, tbl[i].err, tbl[i].cnt,
                 tbl[i].v ? tbl[i].px : 8'h00});
        end

        // Overflow: third frame dropped while both buffers are held
        do_reset();
        do_frame(16'h5566, 16'h7788, 1'b0, 1'b0);
        chk("ovf_cnt1", 32'(FRAME_COUNT), 32'd1);
        do_frame(16'h99AA, 16'hBBCC, 1'b0, 1'b0);
        chk("ovf_cnt2", {31'd0, OVERFLOW}, 32'd0);
        do_frame(16'hDDEE, 16'hFF00, 1'b0, 1'b0);
        chk("ovf_flag", {31'd0, OVERFLOW}, 32'd1);
        chk("ovf_cnt_hold", 32'(FRAME_COUNT), 32'd2);
        add_frame(16'h5566, 16'h7788);
        add_frame(16'h99AA, 16'hBBCC);
        collect_check("ovf", 24);
        chk("ovf_drained", {31'd0, PIX_VALID}, 32'd0);

        // Sequence errors and flag clearing
        do_reset();
        READ2 = 1'b1; step(); step();
        READ2 = 1'b0; step();
        chk("err_r2_only", {31'd0, ROW_ERR}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("err_nostream%0d", i), {23'd0, PIX_VALID, FRAME_COUNT}, 32'd0);
        end
        CLR_FLAGS = 1'b1; step();
        chk("err_clr", {31'd0, ROW_ERR}, 32'd0);
        CLR_FLAGS = 1'b0; READ1 = 1'b1; READ2 = 1'b1; step();
        chk("err_both", {31'd0, ROW_ERR}, 32'd1);
        READ1 = 1'b0; READ2 = 1'b0; CLR_FLAGS = 1'b1; step();
        chk("err_set_wins", {31'd0, ROW_ERR}, 32'd1);
        step();
        chk("err_clr2", {31'd0, ROW_ERR}, 32'd0);
        CLR_FLAGS = 1'b0;

        // Release and completion in the same cycle with both buffers full
        do_reset();
        do_frame(16'h0102, 16'h0304, 1'b0, 1'b0);
        do_frame(16'h0506, 16'h0708, 1'b0, 1'b0);
        chk("sim_full_cnt", 32'(FRAME_COUNT), 32'd2);
        do_frame(16'h0A0B, 16'h0C0D, 1'b0, 1'b1);
        chk("sim_cnt", 32'(FRAME_COUNT), 32'd3);
        chk("sim_no_ovf", {31'd0, OVERFLOW}, 32'd0);
        add_frame(16'h0506, 16'h0708);
        add_frame(16'h0A0B, 16'h0C0D);
        collect_check("sim", 24);

        // Reset in the middle of a stream
        do_reset();
        do_frame(16'hA1B2, 16'hC3D4, 1'b1, 1'b1);
        step();
        chk("rst_first_px", {23'd0, PIX_VALID, PIX_DATA}, {23'd0, 1'b1, 8'hB2});
        step();
        chk("rst_second_px", {23'd0, PIX_VALID, PIX_DATA}, {23'd0, 1'b1, 8'hA1});
        RESET = 1'b1;
        #1;
        chk("rst_async", {11'd0, PIX_VALID, PIX_SOF, PIX_EOF, OVERFLOW, ROW_ERR, FRAME_COUNT, PIX_DATA}, 32'd0);
        step();
        RESET = 1'b0;
        do_frame(16'hA1B2, 16'hC3D4, 1'b1, 1'b1);
        chk("rst_cnt", 32'(FRAME_COUNT), 32'd1);
        add_frame(16'hA1B2, 16'hC3D4);
        collect_check("rst", 12);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
